// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: streams a block of 32-bit words little-endian onto the uart_tx byte channel,
// round-robin shared with a CPU byte port. Optional trailing XOR byte: `define UART_DUMP_CKSUM_EN. Rev 1.0
`default_nettype none

module uart_dump_ctrl #(
  parameter int ADDR_WIDTH = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  cpu_wvalid_i,
  input  logic [7:0]            cpu_wdata_i,
  output logic                  cpu_wready_o,
  output logic                  tx_wvalid_o,
  output logic [7:0]            tx_wdata_o,
  input  logic                  tx_wready_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef UART_DUMP_CKSUM_EN
  localparam logic [2:0] S_CKSUM = 3'd6;
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]           buf_q, buf_d;
  logic [1:0]            idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  txv_q, txv_d;
  logic [7:0]            txd_q, txd_d;
  logic                  cpu_next_q, cpu_next_d;
  logic                  run_q;

  logic [31:0] w_word;
  logic [7:0]  w_strm_byte;
  logic [7:0]  w_strm_data;
  logic        w_strm_req;
  logic        w_can_load;
  logic        w_strm_gnt;
  logic        w_cpu_gnt;

  // Byte 0 of a fresh word is offered straight from the read port while it is being captured.
  assign w_word      = (state_q == S_WAIT) ? mem_rdata_i : buf_q;
  assign w_strm_byte = w_word[{idx_q, 3'b000} +: 8];

`ifdef UART_DUMP_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;
  assign w_strm_data = (state_q == S_CKSUM) ? cksum_q : w_strm_byte;
  assign w_strm_req  = (state_q == S_WAIT) || (state_q == S_SEND) || (state_q == S_CKSUM);
`else
  assign w_strm_data = w_strm_byte;
  assign w_strm_req  = (state_q == S_WAIT) || (state_q == S_SEND);
`endif

  assign w_can_load = !txv_q || tx_wready_i;
  assign w_strm_gnt = w_can_load && w_strm_req && (!cpu_wvalid_i || !cpu_next_q);
  // run_q keeps the combinational CPU grant low while reset is asserted.
  assign w_cpu_gnt  = run_q && w_can_load && cpu_wvalid_i && !w_strm_gnt;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    done_d     = (state_q == S_DONE);
    txv_d      = txv_q;
    txd_d      = txd_q;
    cpu_next_d = cpu_next_q;
`ifdef UART_DUMP_CKSUM_EN
    cksum_d    = cksum_q;
    if (state_q == S_IDLE && start_i) begin
      cksum_d = 8'h00;
    end else if (w_strm_gnt && state_q != S_CKSUM) begin
      cksum_d = cksum_q ^ w_strm_byte;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_i;
          cnt_d   = len_i;
          state_d = (len_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        buf_d   = mem_rdata_i;
        idx_d   = w_strm_gnt ? 2'd1 : 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (w_strm_gnt) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (cnt_q == ADDR_ONE) begin
`ifdef UART_DUMP_CKSUM_EN
              state_d = S_CKSUM;
`else
              state_d = S_DRAIN;
`endif
            end else begin
              addr_d  = addr_q + ADDR_ONE;
              cnt_d   = cnt_q - ADDR_ONE;
              state_d = S_FETCH;
            end
          end
        end
      end
`ifdef UART_DUMP_CKSUM_EN
      S_CKSUM: if (w_strm_gnt) state_d = S_DRAIN;
`endif
      S_DRAIN: if (w_can_load) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_strm_gnt) begin
      txv_d      = 1'b1;
      txd_d      = w_strm_data;
      cpu_next_d = 1'b1;
    end else if (w_cpu_gnt) begin
      txv_d      = 1'b1;
      txd_d      = cpu_wdata_i;
      cpu_next_d = 1'b0;
    end else if (tx_wready_i) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      idx_q      <= 2'd0;
      done_q     <= 1'b0;
      txv_q      <= 1'b0;
      txd_q      <= 8'h00;
      cpu_next_q <= 1'b1;
      run_q      <= 1'b0;
`ifdef UART_DUMP_CKSUM_EN
      cksum_q    <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      txv_q      <= txv_d;
      txd_q      <= txd_d;
      cpu_next_q <= cpu_next_d;
      run_q      <= 1'b1;
`ifdef UART_DUMP_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign mem_re_o     = (state_q == S_FETCH);
  assign mem_addr_o   = addr_q;
  assign cpu_wready_o = w_cpu_gnt;
  assign tx_wvalid_o  = txv_q;
  assign tx_wdata_o   = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_dump_ctrl.sv
// tb_uart_dump_ctrl: directed table of dumps against a small word memory, plus reset-mid-dump sequence.
`default_nettype none

module tb_uart_dump_ctrl;

`ifdef UART_DUMP_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base = 8'h00;
  logic [7:0]  len = 8'h00;
  logic        busy, done, mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_wvalid = 1'b0;
  logic [7:0]  cpu_wdata = 8'hAA;
  logic        cpu_wready;
  logic        tx_wvalid;
  logic [7:0]  tx_wdata;
  logic        tx_wready = 1'b1;

  logic [31:0] mem [256];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  uart_dump_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .cpu_wvalid_i(cpu_wvalid), .cpu_wdata_i(cpu_wdata),
    .cpu_wready_o(cpu_wready), .tx_wvalid_o(tx_wvalid), .tx_wdata_o(tx_wdata),
    .tx_wready_i(tx_wready)
  );

  typedef struct packed {
    logic [7:0]   base;
    logic [7:0]   len;
    logic         rdy;    // 0: ready always, 1: ready on cycles k%3==2
    logic         cpu;    // CPU holds 0xAA from cycle 2 until done
    logic [7:0]   rs;     // cycle of an extra start (0xFF,2) while busy; 0 = none
    logic [7:0]   first;  // first cycle tx_wvalid is high (255 = never)
    logic [7:0]   dcyc;
    logic [7:0]   nb;
    logic [7:0]   nrd;
    logic [7:0]   ncpu;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [159:0] bytes;  // accepted bytes, first at LSB
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else passed++;
  endtask

  function automatic bit rdy_at(input bit mode, input int k);
    return mode ? (k % 3 == 2) : 1'b1;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic [159:0] got;
    int n, nrd, ndone, dcyc, first, ncpu, viol;
    logic [7:0] a0, a1, pd;
    logic pv, pr, b1;
    got = '0; n = 0; nrd = 0; ndone = 0; dcyc = 255; first = 255; ncpu = 0; viol = 0;
    a0 = 8'h00; a1 = 8'h00; pv = 1'b0; pr = 1'b0; pd = 8'h00; b1 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base = v.base; len = v.len; cpu_wvalid = 1'b0; tx_wready = rdy_at(v.rdy, 0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 1) b1 = busy;
      if (done) begin
        ndone++;
        if (dcyc == 255) dcyc = k;
      end
      if (tx_wvalid && first == 255) first = k;
      if (pv && !pr && (!tx_wvalid || tx_wdata !== pd)) viol++;
      pv = tx_wvalid; pr = tx_wready; pd = tx_wdata;
      if (dcyc == 255 || k <= dcyc) begin
        if (tx_wvalid && tx_wready) begin
          if (n < 20) got[8*n +: 8] = tx_wdata;
          n++;
        end
        if (cpu_wready) ncpu++;
      end
      if (mem_re) begin
        if (nrd == 0) a0 = mem_addr;
        else if (nrd == 1) a1 = mem_addr;
        nrd++;
      end
      if (dcyc != 255 && k >= dcyc + 3) break;
      @(posedge clk); #1;
      start = (v.rs != 0) && (k + 1 == int'(v.rs));
      if (start) begin base = 8'hFF; len = 8'h02; end
      cpu_wvalid = v.cpu && (k + 1 >= 2) && (dcyc == 255);
      tx_wready  = (dcyc != 255) ? 1'b1 : rdy_at(v.rdy, k + 1);
    end
    start = 1'b0; cpu_wvalid = 1'b0; tx_wready = 1'b1;
    chk({nm, "_busy_c1"}, 160'(b1), 160'(1'b1));
    chk({nm, "_first_tx"}, 160'(first), 160'(v.first));
    chk({nm, "_done_cyc"}, 160'(dcyc), 160'(v.dcyc));
    chk({nm, "_done_cnt"}, 160'(ndone), 160'(1));
    chk({nm, "_nbytes"}, 160'(n), 160'(v.nb));
    chk({nm, "_bytes"}, got, v.bytes);
    chk({nm, "_reads"}, 160'(nrd), 160'(v.nrd));
    if (v.nrd > 0) chk({nm, "_addr0"}, 160'(a0), 160'(v.a0));
    if (v.nrd > 1) chk({nm, "_addr1"}, 160'(a1), 160'(v.a1));
    chk({nm, "_cpu_gnt"}, 160'(ncpu), 160'(v.ncpu));
    chk({nm, "_hold"}, 160'(viol), 160'(0));
  endtask

  initial begin
    vec_t rv;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h88776655;
    mem[8'hFF] = 32'hD4C3B2A1;
    mem[8'h00] = 32'h08070605;

    // single word, ready always
    tbl[0] = '{base:8'h10, len:8'd1, rdy:1'b0, cpu:1'b0, rs:8'd0, first:8'd3,
               dcyc: CK ? 8'd9 : 8'd8, nb: CK ? 8'd5 : 8'd4, nrd:8'd1, ncpu:8'd0,
               a0:8'h10, a1:8'h00, bytes: CK ? 160'h44_44332211 : 160'h44332211};
    // backpressure, ready 1-of-3
    tbl[1] = '{base:8'h10, len:8'd1, rdy:1'b1, cpu:1'b0, rs:8'd0, first:8'd3,
               dcyc: CK ? 8'd19 : 8'd16, nb: CK ? 8'd5 : 8'd4, nrd:8'd1, ncpu:8'd0,
               a0:8'h10, a1:8'h00, bytes: CK ? 160'h44_44332211 : 160'h44332211};
    // contention with CPU byte 0xAA
    tbl[2] = '{base:8'h10, len:8'd2, rdy:1'b0, cpu:1'b1, rs:8'd0, first:8'd3,
               dcyc: CK ? 8'd22 : 8'd20, nb: CK ? 8'd20 : 8'd18, nrd:8'd2,
               ncpu: CK ? 8'd12 : 8'd11, a0:8'h10, a1:8'h11,
               bytes: CK ? 160'hAAAA88AA_88AA77AA_66AA55AA_44AA33AA_22AA11AA
                         : 160'hAAAA_88AA_77AA_66AA_55AA_44AA_33AA_22AA_11AA};
    // address wrap 0xFF -> 0x00
    tbl[3] = '{base:8'hFF, len:8'd2, rdy:1'b0, cpu:1'b0, rs:8'd0, first:8'd3,
               dcyc: CK ? 8'd14 : 8'd13, nb: CK ? 8'd9 : 8'd8, nrd:8'd2, ncpu:8'd0,
               a0:8'hFF, a1:8'h00,
               bytes: CK ? 160'h08_08070605_D4C3B2A1 : 160'h08070605_D4C3B2A1};
    // zero length
    tbl[4] = '{base:8'h10, len:8'd0, rdy:1'b0, cpu:1'b0, rs:8'd0, first:8'd255,
               dcyc:8'd2, nb:8'd0, nrd:8'd0, ncpu:8'd0, a0:8'h00, a1:8'h00, bytes:160'h0};
    // start while busy is ignored
    tbl[5] = tbl[0];
    tbl[5].rs = 8'd3;

    #1;
    chk("reset_outs", 160'({busy, done, mem_re, mem_addr, cpu_wready, tx_wvalid, tx_wdata}), 160'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 160'({busy, done, mem_re, cpu_wready, tx_wvalid}), 160'h0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // reset in the middle of a two-word dump
    @(posedge clk); #1;
    start = 1'b1; base = 8'h10; len = 8'd2; tx_wready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_valid", 160'(tx_wvalid), 160'(1'b1));
    rst_n = 1'b0; cpu_wvalid = 1'b1;
    #1;
    chk("mid_rst_outs", 160'({busy, done, mem_re, mem_addr, cpu_wready, tx_wvalid, tx_wdata}), 160'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1; cpu_wvalid = 1'b0;
    rv = '{base:8'hFF, len:8'd1, rdy:1'b0, cpu:1'b0, rs:8'd0, first:8'd3,
           dcyc: CK ? 8'd9 : 8'd8, nb: CK ? 8'd5 : 8'd4, nrd:8'd1, ncpu:8'd0,
           a0:8'hFF, a1:8'h00, bytes: CK ? 160'h04_D4C3B2A1 : 160'hD4C3B2A1};
    run_vec(rv, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
